// File: rtl/ifetch_pkg.sv
// Shared rvga types and constants for the fetch stage.
// Defines the control word, fetch FSM states and the PC step.
package ifetch_pkg;

  localparam logic [31:0] RVGA_WORDSIZE = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FULL,
    FLUSH
  } ifetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } rvga_cword;

  localparam rvga_cword RVGA_BUBBLE = '0;

  function automatic rvga_cword make_cword(
    input logic [31:0] inst,
    input logic [31:0] pc
  );
    rvga_cword c;
    c      = RVGA_BUBBLE;
    c.inst = inst;
    c.pc   = pc;
    return c;
  endfunction

endpackage

// File: rtl/ifetch.sv
// Fetch stage: owns PC, single-outstanding imem requests, feeds decode.
// Ports: clk/rst_n, stall, redirect/redirect_pc, imem_* bus, if_de_cword.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] WORDSIZE = RVGA_WORDSIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output rvga_cword   if_de_cword
);

  ifetch_state_t state;
  logic [31:0]   pc;
  logic [31:0]   req_addr;
  logic [31:0]   buf_inst;
  logic [31:0]   tgt;
  logic [31:0]   pc_inc;

  assign tgt       = {redirect_pc[31:2], 2'b00};
  assign pc_inc    = pc + WORDSIZE;
  assign imem_req  = (state == FETCH) || (state == FLUSH);
  // In FLUSH the squashed request stays on the bus until acked.
  assign imem_addr = (state == FLUSH) ? req_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      buf_inst    <= '0;
      if_de_cword <= RVGA_BUBBLE;
    end else begin
      if (redirect) begin
        if_de_cword <= RVGA_BUBBLE;
      end
      unique case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            pc <= tgt;
            if (!imem_ack) begin
              req_addr <= pc;
              state    <= FLUSH;
            end
          end else if (imem_ack) begin
            if (!stall) begin
              if_de_cword <= make_cword(imem_rdata, pc);
              pc          <= pc_inc;
            end else begin
              buf_inst <= imem_rdata;
              state    <= FULL;
            end
          end else if (!stall) begin
            if_de_cword <= RVGA_BUBBLE;
          end
        end
        FULL: begin
          if (redirect) begin
            pc    <= tgt;
            state <= FETCH;
          end else if (!stall) begin
            if_de_cword <= make_cword(buf_inst, pc);
            pc          <= pc_inc;
            state       <= FETCH;
          end
        end
        FLUSH: begin
          if (redirect) begin
            pc <= tgt;
          end
          if (imem_ack) begin
            state <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus random
// traffic against a queue-based fetch reference model.
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  rvga_cword   if_de_cword;

  int n_checks = 0;
  int n_errors = 0;

  ifetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_de_cword (if_de_cword)
  );

  always #5 clk = ~clk;

  // reference model
  bit          m_started;
  bit          m_stale;
  logic [31:0] m_stale_addr;
  logic [31:0] m_pc;
  logic [31:0] m_held[$];
  rvga_cword   m_cw;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[13:0], 18'h00013} ^ {a[31:14], 14'h0};
  endfunction

  function automatic rvga_cword mk(input logic [31:0] i, input logic [31:0] p);
    rvga_cword c;
    c = '0;
    c.inst = i;
    c.pc = p;
    return c;
  endfunction

  function automatic bit m_req();
    return m_started && (m_stale || m_held.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_stale = 0;
    m_stale_addr = '0;
    m_pc = '0;
    m_held.delete();
    m_cw = '0;
  endtask

  task automatic model_step(input bit st, input bit rd,
                            input logic [31:0] rpc, input bit a);
    logic [31:0] t;
    t = {rpc[31:2], 2'b00};
    if (!m_started) begin
      m_started = 1;
    end else if (m_stale) begin
      if (rd) begin m_pc = t; m_cw = '0; end
      if (a) m_stale = 0;
    end else if (m_held.size() != 0) begin
      if (rd) begin
        m_held.delete(); m_pc = t; m_cw = '0;
      end else if (!st) begin
        m_cw = mk(m_held.pop_front(), m_pc);
        m_pc = m_pc + 32'd4;
      end
    end else if (rd) begin
      m_cw = '0;
      if (!a) begin m_stale = 1; m_stale_addr = m_pc; end
      m_pc = t;
    end else if (a) begin
      if (!st) begin
        m_cw = mk(mem(m_pc), m_pc);
        m_pc = m_pc + 32'd4;
      end else begin
        m_held.push_back(mem(m_pc));
      end
    end else if (!st) begin
      m_cw = '0;
    end
  endtask

  // drive one cycle; ack only offered while a request is expected
  task automatic cycle(input bit st, input bit rd,
                       input logic [31:0] rpc, input bit ak);
    bit a;
    a = ak && m_req();
    stall = st;
    redirect = rd;
    redirect_pc = rpc;
    imem_ack = a;
    imem_rdata = a ? mem(imem_addr) : 32'hDEAD_BEEF;
    model_step(st, rd, rpc, a);
    @(posedge clk);
    #1;
    stall = 0; redirect = 0; imem_ack = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    stall = 0; redirect = 0; imem_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_checks++; if (if_de_cword !== RVGA_BUBBLE) begin n_errors++; $display("FAIL rst_cw got %h exp 0", if_de_cword); end
    rst_n = 1;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL idle_req got %b exp 0", imem_req); end
    cycle(0, 0, 0, 0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_errors++; $display("FAIL first_req got %b/%h exp 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_zero_wait();
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (imem_addr !== 32'(4 * k)) begin n_errors++; $display("FAIL zw_addr got %h exp %h", imem_addr, 4 * k); end
      cycle(0, 0, 0, 1);
      n_checks++; if (if_de_cword !== mk(mem(32'(4 * k)), 32'(4 * k))) begin n_errors++; $display("FAIL zw_cw got %h exp pc %h", if_de_cword, 4 * k); end
    end
  endtask

  task automatic test_stall_full();
    n_checks++; if (imem_addr !== 32'h8) begin n_errors++; $display("FAIL st_addr got %h exp 8", imem_addr); end
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL full_req got %b exp 0", imem_req); end
    n_checks++; if (if_de_cword !== mk(mem(32'h4), 32'h4)) begin n_errors++; $display("FAIL full_hold got %h exp pc 4", if_de_cword); end
    cycle(0, 0, 0, 0);
    n_checks++; if (if_de_cword !== mk(mem(32'h8), 32'h8)) begin n_errors++; $display("FAIL full_dlv got %h exp pc 8", if_de_cword); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_errors++; $display("FAIL full_next got %b/%h exp 1/c", imem_req, imem_addr); end
  endtask

  task automatic test_flush();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    n_checks++; if (if_de_cword !== RVGA_BUBBLE) begin n_errors++; $display("FAIL noack_bub got %h exp 0", if_de_cword); end
    cycle(0, 1, 32'h100, 0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_errors++; $display("FAIL fl_addr got %b/%h exp 1/10", imem_req, imem_addr); end
    cycle(0, 0, 0, 0);
    n_checks++; if (imem_addr !== 32'h10) begin n_errors++; $display("FAIL fl_hold got %h exp 10", imem_addr); end
    cycle(0, 0, 0, 1);
    n_checks++; if (imem_addr !== 32'h100 || if_de_cword !== RVGA_BUBBLE) begin n_errors++; $display("FAIL fl_stale got %h/%h exp 100/0", imem_addr, if_de_cword); end
    cycle(0, 0, 0, 1);
    n_checks++; if (if_de_cword !== mk(mem(32'h100), 32'h100)) begin n_errors++; $display("FAIL fl_tgt got %h exp pc 100", if_de_cword); end
  endtask

  task automatic test_redirect_full();
    cycle(1, 0, 0, 1);
    cycle(1, 1, 32'h203, 0);
    n_checks++; if (if_de_cword !== RVGA_BUBBLE) begin n_errors++; $display("FAIL rf_bub got %h exp 0", if_de_cword); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_errors++; $display("FAIL rf_addr got %b/%h exp 1/200", imem_req, imem_addr); end
  endtask

  task automatic test_double_redirect();
    cycle(0, 1, 32'h40, 0);
    cycle(0, 1, 32'h80, 0);
    n_checks++; if (imem_addr !== 32'h200) begin n_errors++; $display("FAIL dr_stale got %h exp 200", imem_addr); end
    cycle(0, 0, 0, 1);
    n_checks++; if (imem_addr !== 32'h80) begin n_errors++; $display("FAIL dr_addr got %h exp 80", imem_addr); end
    cycle(0, 0, 0, 1);
    n_checks++; if (if_de_cword !== mk(mem(32'h80), 32'h80)) begin n_errors++; $display("FAIL dr_cw got %h exp pc 80", if_de_cword); end
  endtask

  task automatic test_async_reset();
    cycle(0, 1, 32'h24, 1);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin n_errors++; $display("FAIL ar_pre got %b/%h exp 1/24", imem_req, imem_addr); end
    #2;
    rst_n = 0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || if_de_cword !== RVGA_BUBBLE) begin n_errors++; $display("FAIL ar_drop got %b/%h exp 0/0", imem_req, if_de_cword); end
    @(posedge clk);
    #1;
    rst_n = 1;
    imem_ack = 1;
    imem_rdata = mem(32'h24);
    @(posedge clk);
    #1;
    imem_ack = 0;
    model_reset();
    m_started = 1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_de_cword !== RVGA_BUBBLE) begin n_errors++; $display("FAIL ar_restart got %b/%h/%h exp 1/0/0", imem_req, imem_addr, if_de_cword); end
    cycle(0, 0, 0, 1);
    n_checks++; if (if_de_cword !== mk(mem(32'h0), 32'h0)) begin n_errors++; $display("FAIL ar_cw got %h exp pc 0", if_de_cword); end
  endtask

  task automatic test_wrap();
    cycle(0, 1, 32'hFFFF_FFFE, 1);
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC || if_de_cword !== RVGA_BUBBLE) begin n_errors++; $display("FAIL wr_tgt got %h/%h exp fffffffc/0", imem_addr, if_de_cword); end
    cycle(0, 0, 0, 1);
    n_checks++; if (if_de_cword !== mk(mem(32'hFFFF_FFFC), 32'hFFFF_FFFC)) begin n_errors++; $display("FAIL wr_cw got %h exp pc fffffffc", if_de_cword); end
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL wr_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    do_reset();
    rst_n = 1;
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      n_checks++; if (imem_req !== m_req()) begin n_errors++; $display("FAIL rnd_req @%0d got %b exp %b", i, imem_req, m_req()); end
      if (m_req()) begin
        n_checks++; if (imem_addr !== m_addr()) begin n_errors++; $display("FAIL rnd_addr @%0d got %h exp %h", i, imem_addr, m_addr()); end
      end
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
            rpc, $urandom_range(0, 1) == 1);
      n_checks++; if (if_de_cword !== m_cw) begin n_errors++; $display("FAIL rnd_cw @%0d got %h exp %h", i, if_de_cword, m_cw); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_full();
    test_flush();
    test_redirect_full();
    test_double_redirect();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
